al_fifo_rd_stream: RTL and testbench
====================================

Name: al_fifo_rd_stream

Overview:
- Read-side controller for the 8K hard FIFO primitive, on the read clock domain.
- Drives the FIFO read port: re, ore and rprst. Captures returned words and presents them as a valid/ready stream to downstream logic.
- Hides the FIFO read latency, which is 1 cycle with NOREG and 2 cycles with OUTREG. Sustains one word per cycle and never reads while empty.
- Also provides a flush sequence that discards buffered and in-flight data and resets the FIFO read pointer.

Parameters:
- DATA_WIDTH, 18: FIFO read word width; legal values 1, 2, 4, 9, 18. Upper bits of fifo_do are ignored when the width is below 18.
- READ_LATENCY, 1: cycles from fifo_re to valid fifo_do. 1 = NOREG, 2 = OUTREG; any other value is a fatal elaboration error.
- BUF_DEPTH, READ_LATENCY+2: entries in the internal capture buffer. Must be at least READ_LATENCY+2 for full throughput.

Ports:
- clkr, in, 1: read clock; everything is synchronous to its rising edge.
- rst, in, 1: synchronous, active-high reset.
- fifo_do, in, 18: FIFO read data, {dob,doa}.
- fifo_empty, in, 1: FIFO empty_flag.
- fifo_aempty, in, 1: FIFO aempty_flag.
- fifo_re, out, 1: FIFO read enable.
- fifo_ore, out, 1: FIFO output-register enable, driven to both orea and oreb.
- fifo_rprst, out, 1: FIFO read-pointer reset pulse.
- m_data, out, DATA_WIDTH: stream data.
- m_valid, out, 1: stream valid.
- m_ready, in, 1: stream ready.
- flush_req, in, 1: level request to flush.
- flush_done, out, 1: single-cycle pulse when a flush completes.

Behaviour:
- Reset values: fifo_re=0, fifo_ore=0, fifo_rprst=0, m_valid=0, m_data=0, flush_done=0. Reset also sets state=S_RUN, inflight=0, buffer count=0, and clears both buffer pointers.
- A reset asserted mid-operation abandons in-flight reads with no rprst pulse. The FIFO is reset by its own rst.
- Handshake:
  - A word transfers on a cycle where m_valid && m_ready.
  - Once m_valid is high, m_valid and m_data hold until the transfer.
  - m_data is driven from the buffer head register; there is no combinational path from fifo_do to m_data.
- Read latency pipeline:
  - A shift register of depth READ_LATENCY tracks issued reads.
  - A read issued at cycle t is captured into the buffer at t+READ_LATENCY.
  - The earliest m_valid is t+READ_LATENCY+1.
- Read issue rule, evaluated in S_RUN: fifo_re = !fifo_empty && (inflight + count < BUF_DEPTH) && !(fifo_aempty && inflight != 0).
  - Near empty, at most one read is outstanding, so the one-cycle lag of empty_flag can never cause an underflow read.
  - Away from empty, reads issue back-to-back.
- fifo_ore: equals fifo_re delayed by one cycle when READ_LATENCY=2; constant 1 when READ_LATENCY=1.
- Counters: inflight is 0..READ_LATENCY; count is 0..BUF_DEPTH. Both increment and decrement in the same cycle as needed. Buffer pointers wrap modulo BUF_DEPTH.
- Buffer full: the credit rule guarantees a capture never overflows. A capture into a full buffer is an assertion failure.
- Simultaneous capture and pop on an empty buffer: the word enters and m_valid rises the following cycle. There is no bypass.
- State machine:
  - S_RUN: normal operation. If flush_req is sampled high, go to S_DRAIN; fifo_re is 0 from that cycle on.
  - S_DRAIN: m_valid=0, and the buffer is cleared on entry. Returning in-flight words are discarded. Go to S_RPRST when inflight==0.
  - S_RPRST: fifo_rprst=1 for exactly one cycle, then go to S_DONE.
  - S_DONE: flush_done=1 for one cycle. Return to S_RUN once flush_req is low; stay in S_DONE (flush_done low after the first cycle) while flush_req is still high.
- A transfer may complete on the same cycle that flush_req is first sampled; that word counts as delivered.

Optional Feature:
- Macro: AL_FIFO_RD_STAT_EN.
- When defined, add these output ports:
  - stat_words, 16 bits: counts stream transfers.
  - stat_starve, 16 bits: counts S_RUN cycles with m_ready=1, m_valid=0 and fifo_empty=1.
  - Both counters wrap at 16'hFFFF to 0, clear on rst, and hold their value during a flush.
- When not defined: no stat ports and no counter logic; all other behaviour is identical.

Decomposition:
- Package al_fifo_rd_pkg holds:
  - the state encoding typedef (S_RUN, S_DRAIN, S_RPRST, S_DONE);
  - constants LAT_NOREG=1, LAT_OUTREG=2 and MAX_FIFO_DW=18;
  - the function computing the minimum buffer depth from latency.
- One sub-module, al_fifo_rd_buf: a parameterised circular capture buffer with push, pop, clear, count, head data and a full-assert.

Test Plan:
- Burst: FIFO preloaded with 16 words 0x00..0x0F, m_ready=1, READ_LATENCY=2 -> first m_valid 3 cycles after the first fifo_re, then 16 consecutive transfers in order; fifo_re never high while fifo_empty=1.
- Backpressure: m_ready toggles 1,0,0,1 repeating over 32 words -> no loss or duplication; count never exceeds 4; m_data stable while stalled.
- Near empty: FIFO holds 2 words with aempty=1 -> reads are spaced with at most one in flight; exactly 2 transfers; no underflow read.
- Flush: flush_req asserted with 2 reads in flight and 3 words buffered -> m_valid drops the next cycle, in-flight words are discarded, fifo_rprst is a single pulse after inflight reaches 0, followed by the flush_done pulse.
- Reset: rst asserted mid-burst -> next cycle all outputs are 0, count and inflight are 0, and no rprst pulse occurs.
- Stats (with AL_FIFO_RD_STAT_EN): 70000 transfers -> stat_words = 70000 mod 65536 = 4464.

Source files
------------

// File: rtl/al_fifo_rd_pkg.sv
// Shared definitions for the 8K hard FIFO read-side stream controller:
// flush state encoding, FIFO read latency modes and buffer sizing.
package al_fifo_rd_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_RPRST = 2'd2,
    S_DONE  = 2'd3
  } rd_state_e;

  localparam int LAT_NOREG   = 1;
  localparam int LAT_OUTREG  = 2;
  localparam int MAX_FIFO_DW = 18;

  // One slot per outstanding read plus one for the head word and one so a
  // capture and a pop can overlap without stalling the read port.
  function automatic int min_buf_depth(input int read_latency);
    return read_latency + 2;
  endfunction

endpackage

// File: rtl/al_fifo_rd_buf.sv
// Circular capture buffer for words returning from the FIFO read port.
// Head word is presented from storage; clear discards all entries.
module al_fifo_rd_buf #(
  parameter  int DATA_WIDTH = 18,
  parameter  int DEPTH      = 3,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CW-1:0]         count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full = (count == CW'(DEPTH));
  assign head = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // The read credit rule must keep a capture from ever landing on a full buffer.
  always_ff @(posedge clk) begin
    if (!rst && !clr && push) assert (!full);
  end

endmodule

// File: rtl/al_fifo_rd_stream.sv
// Read-side controller for the 8K hard FIFO: issues reads, hides read latency,
// presents a valid/ready stream and runs the flush sequence. Optional
// transfer/starvation counters are built when AL_FIFO_RD_STAT_EN is defined.
module al_fifo_rd_stream
  import al_fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH   = 18,
  parameter int READ_LATENCY = LAT_NOREG,
  parameter int BUF_DEPTH    = min_buf_depth(READ_LATENCY)
) (
  input  logic                   clkr,
  input  logic                   rst,
  input  logic [MAX_FIFO_DW-1:0] fifo_do,
  input  logic                   fifo_empty,
  input  logic                   fifo_aempty,
  output logic                   fifo_re,
  output logic                   fifo_ore,
  output logic                   fifo_rprst,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  input  logic                   flush_req,
  output logic                   flush_done
`ifdef AL_FIFO_RD_STAT_EN
  ,
  output logic [15:0]            stat_words,
  output logic [15:0]            stat_starve
`endif
);

  if (READ_LATENCY != LAT_NOREG && READ_LATENCY != LAT_OUTREG) begin : g_bad_latency
    $fatal(1, "al_fifo_rd_stream: READ_LATENCY must be 1 (NOREG) or 2 (OUTREG)");
  end
  if (BUF_DEPTH < min_buf_depth(READ_LATENCY)) begin : g_bad_depth
    $fatal(1, "al_fifo_rd_stream: BUF_DEPTH below READ_LATENCY+2");
  end
  if (DATA_WIDTH != 1 && DATA_WIDTH != 2 && DATA_WIDTH != 4 &&
      DATA_WIDTH != 9 && DATA_WIDTH != 18) begin : g_bad_width
    $fatal(1, "al_fifo_rd_stream: DATA_WIDTH must be 1, 2, 4, 9 or 18");
  end

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int IW = $clog2(READ_LATENCY + 1);

  rd_state_e               state;
  logic [READ_LATENCY-1:0] lat_sr;
  logic [IW-1:0]           inflight;
  logic [CW-1:0]           buf_count;
  logic [SW-1:0]           credit_used;
  logic                    capture;
  logic                    push;
  logic                    pop;
  logic                    clr;
  logic                    re_ok;
  logic                    unused_do;

  assign unused_do = ^fifo_do;

  // Issue stage: never read near empty with a read still outstanding.
  assign credit_used = SW'(inflight) + SW'(buf_count);
  assign re_ok       = !fifo_empty && (credit_used < SW'(BUF_DEPTH)) &&
                       !(fifo_aempty && inflight != '0);
  assign fifo_re     = !rst && (state == S_RUN) && !flush_req && re_ok;

  always_ff @(posedge clkr) begin
    if (rst) begin
      lat_sr   <= '0;
      inflight <= '0;
      fifo_ore <= 1'b0;
    end else begin
      lat_sr   <= (lat_sr << 1) | READ_LATENCY'(fifo_re);
      inflight <= inflight + IW'(fifo_re) - IW'(capture);
      fifo_ore <= (READ_LATENCY == LAT_OUTREG) ? fifo_re : 1'b1;
    end
  end

  // Capture stage: returned words land in the buffer READ_LATENCY cycles later.
  assign capture = lat_sr[READ_LATENCY-1];
  assign push    = capture && (state == S_RUN);
  assign clr     = (state == S_RUN) && flush_req;
  assign m_valid = (buf_count != '0);
  assign pop     = m_valid && m_ready;

  al_fifo_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk   (clkr),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (fifo_do[DATA_WIDTH-1:0]),
    .head  (m_data),
    .count (buf_count)
  );

  always_ff @(posedge clkr) begin
    if (rst) begin
      state      <= S_RUN;
      fifo_rprst <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      fifo_rprst <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        S_RUN:   if (flush_req) state <= S_DRAIN;
        S_DRAIN: if (inflight == '0) begin
          state      <= S_RPRST;
          fifo_rprst <= 1'b1;
        end
        S_RPRST: begin
          state      <= S_DONE;
          flush_done <= 1'b1;
        end
        S_DONE:  if (!flush_req) state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

`ifdef AL_FIFO_RD_STAT_EN
  always_ff @(posedge clkr) begin
    if (rst) begin
      stat_words  <= '0;
      stat_starve <= '0;
    end else begin
      if (pop) stat_words <= stat_words + 16'd1;
      if (state == S_RUN && m_ready && !m_valid && fifo_empty)
        stat_starve <= stat_starve + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_al_fifo_rd_stream.sv
// Bench for al_fifo_rd_stream with OUTREG latency and a 4-entry buffer, driven
// by a queue-based model of the hard FIFO and a scoreboard of expected words.
module tb_al_fifo_rd_stream;

  localparam int DW    = 18;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clkr = 1'b0;
  logic          rst;
  logic [17:0]   fifo_do;
  logic          fifo_empty;
  logic          fifo_aempty;
  logic          fifo_re;
  logic          fifo_ore;
  logic          fifo_rprst;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          flush_req;
  logic          flush_done;
`ifdef AL_FIFO_RD_STAT_EN
  logic [15:0]   stat_words;
  logic [15:0]   stat_starve;
`endif

  always #5 clkr = ~clkr;

  al_fifo_rd_stream #(
    .DATA_WIDTH   (DW),
    .READ_LATENCY (LAT),
    .BUF_DEPTH    (DEPTH)
  ) dut (
    .clkr        (clkr),
    .rst         (rst),
    .fifo_do     (fifo_do),
    .fifo_empty  (fifo_empty),
    .fifo_aempty (fifo_aempty),
    .fifo_re     (fifo_re),
    .fifo_ore    (fifo_ore),
    .fifo_rprst  (fifo_rprst),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .flush_req   (flush_req),
    .flush_done  (flush_done)
`ifdef AL_FIFO_RD_STAT_EN
    ,
    .stat_words  (stat_words),
    .stat_starve (stat_starve)
`endif
  );

  typedef struct {
    int n_words;
    int ae_th;
    int ready_mode;   // 0 always ready, 1 pattern 1,0,0,1, 2 random
    int push_pct;     // 0 preload everything, else trickle-in probability
    int exp_xfers;
    int exp_span;     // first-valid to last-transfer distance, -1 unchecked
  } vec_t;

  vec_t vecs[4];

  logic [17:0]   q[$];
  logic [17:0]   exp_q[$];
  logic [17:0]   d1;
  logic [17:0]   next_word;
  logic [DW-1:0] data_prev;
  logic          h1, h2;
  bit            in_run, stall_prev;
  int            ae_th, checks, errors, cyc, buffered, xfers, pending, push_pct;
  int            first_re, first_valid, last_xfer, last_re;
  int            rprst_seen, done_seen, rprst_cyc, done_cyc;

  task automatic chk(input string name, input longint act, input longint exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_word(input logic [17:0] v);
    q.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_re"},    fifo_re,    0);
    chk({tag, "_ore"},   fifo_ore,   0);
    chk({tag, "_rprst"}, fifo_rprst, 0);
    chk({tag, "_valid"}, m_valid,    0);
    chk({tag, "_data"},  m_data,     0);
    chk({tag, "_done"},  flush_done, 0);
  endtask

  // One read-clock cycle: observe the DUT mid-cycle, then advance the FIFO model.
  task automatic tick();
    bit re_s, ore_s, rst_s, rprst_s, xfer;
    #1;
    re_s    = fifo_re;
    ore_s   = fifo_ore;
    rst_s   = rst;
    rprst_s = fifo_rprst;
    xfer    = m_valid && m_ready;
    if (re_s) begin
      chk("re_while_empty", fifo_empty, 0);
      if (fifo_aempty) chk("aempty_outstanding", h1 + h2, 0);
      last_re = cyc;
      if (first_re < 0) first_re = cyc;
    end
    chk("ore_follows_re", ore_s, h1);
    if (stall_prev) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, data_prev);
    end
    stall_prev = m_valid && !m_ready && !rst && !flush_req;
    data_prev  = m_data;
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (xfer) begin
      chk("xfer_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("xfer_data", m_data, exp_q.pop_front());
      xfers++;
      last_xfer = cyc;
    end
    if (fifo_rprst) begin rprst_seen++; rprst_cyc = cyc; end
    if (flush_done) begin done_seen++; done_cyc = cyc; end
    buffered += int'(h2) - int'(xfer);
    if (in_run) chk("buffered_le_depth", buffered <= DEPTH, 1);
    @(posedge clkr);
    #1;
    if (rst_s) begin
      q.delete();
      d1      = '0;
      fifo_do = '0;
    end else begin
      if (ore_s) fifo_do = d1;
      if (re_s) begin
        chk("underflow_read", q.size() > 0, 1);
        if (q.size() > 0) d1 = q.pop_front();
      end
      if (rprst_s) q.delete();
    end
    if (pending > 0 && $urandom_range(99) < push_pct) begin
      push_word(next_word);
      next_word++;
      pending--;
    end
    fifo_empty  = (q.size() == 0);
    fifo_aempty = (q.size() <= ae_th);
    h2  = rst_s ? 1'b0 : h1;
    h1  = rst_s ? 1'b0 : re_s;
    cyc++;
    @(negedge clkr);
  endtask

  initial begin
    int f, exp_rprst, c;
    vecs[0] = '{16, 0, 0, 0,  16, 15};
    vecs[1] = '{32, 0, 1, 0,  32, -1};
    vecs[2] = '{2,  3, 0, 0,  2,  -1};
    vecs[3] = '{48, 2, 2, 40, 48, -1};

    rst = 1'b1; m_ready = 1'b0; flush_req = 1'b0; fifo_do = '0;
    fifo_empty = 1'b1; fifo_aempty = 1'b1; d1 = '0; h1 = 1'b0; h2 = 1'b0;
    ae_th = 0; checks = 0; errors = 0; cyc = 0; buffered = 0; xfers = 0;
    pending = 0; push_pct = 0; next_word = '0; in_run = 1'b0; stall_prev = 1'b0;
    first_re = -1; first_valid = -1; last_xfer = -1; last_re = -1;
    rprst_seen = 0; done_seen = 0; rprst_cyc = -1; done_cyc = -1;

    @(negedge clkr);
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      ae_th = vecs[i].ae_th; xfers = 0; first_re = -1; first_valid = -1;
      buffered = 0; in_run = 1'b1;
      if (vecs[i].push_pct == 0) begin
        for (int k = 0; k < vecs[i].n_words; k++) push_word(18'(i * 256 + k));
      end else begin
        pending = vecs[i].n_words; push_pct = vecs[i].push_pct;
        next_word = 18'(i * 256);
      end
      for (int k = 0; k < 3000 && xfers < vecs[i].exp_xfers; k++) begin
        case (vecs[i].ready_mode)
          0:       m_ready = 1'b1;
          1:       m_ready = (k % 4 == 0) || (k % 4 == 3);
          default: m_ready = 1'($urandom_range(1));
        endcase
        tick();
      end
      m_ready = 1'b1;
      repeat (6) tick();
      chk("xfer_count", xfers, vecs[i].exp_xfers);
      chk("first_valid_latency", first_valid - first_re, LAT + 1);
      if (vecs[i].exp_span >= 0) chk("burst_span", last_xfer - first_valid, vecs[i].exp_span);
      chk("scoreboard_drained", exp_q.size(), 0);
    end

    // Flush with two reads outstanding and words buffered.
    ae_th = 0; xfers = 0; buffered = 0; in_run = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 12; k++) push_word(18'h1000 + 18'(k));
    c = 0;
    while (!(h1 && h2 && buffered >= 1) && c < 50) begin tick(); c++; end
    chk("flush_setup_reached", c < 50, 1);
    flush_req = 1'b1; in_run = 1'b0; rprst_seen = 0; done_seen = 0;
    f = cyc;
    tick();
    exp_q.delete();
    exp_rprst = ((f + 1 > last_re + LAT + 1) ? f + 1 : last_re + LAT + 1) + 1;
    for (int k = 0; k < 10; k++) begin
      chk("flush_valid_low", m_valid, 0);
      chk("flush_re_low", fifo_re, 0);
      tick();
    end
    flush_req = 1'b0;
    repeat (4) tick();
    chk("rprst_pulses", rprst_seen, 1);
    chk("rprst_cycle", rprst_cyc, exp_rprst);
    chk("done_pulses", done_seen, 1);
    chk("done_cycle", done_cyc, rprst_cyc + 1);
    buffered = 0; in_run = 1'b1; xfers = 0;
    for (int k = 0; k < 5; k++) push_word(18'h2000 + 18'(k));
    for (int k = 0; k < 100 && xfers < 5; k++) tick();
    repeat (4) tick();
    chk("post_flush_count", xfers, 5);

    // Reset in the middle of a burst.
    xfers = 0; rprst_seen = 0;
    for (int k = 0; k < 12; k++) push_word(18'h3000 + 18'(k));
    repeat (5) tick();
    rst = 1'b1; in_run = 1'b0;
    tick();
    chk_zero("mid_reset");
    tick();
    rst = 1'b0;
    exp_q.delete(); buffered = 0; in_run = 1'b1; xfers = 0;
    first_re = -1; first_valid = -1;
    for (int k = 0; k < 6; k++) push_word(18'h4000 + 18'(k));
    for (int k = 0; k < 100 && xfers < 6; k++) tick();
    repeat (4) tick();
    chk("post_reset_count", xfers, 6);
    chk("post_reset_latency", first_valid - first_re, LAT + 1);
    chk("reset_no_rprst", rprst_seen, 0);

`ifdef AL_FIFO_RD_STAT_EN
    rst = 1'b1; in_run = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("stat_words_reset", stat_words, 0);
    chk("stat_starve_reset", stat_starve, 0);
    exp_q.delete(); buffered = 0; in_run = 1'b1; xfers = 0; ae_th = 0;
    m_ready = 1'b1; pending = 70000; push_pct = 100; next_word = '0;
    for (int k = 0; k < 72000 && xfers < 70000; k++) tick();
    chk("stat_words_wrap", stat_words, 70000 % 65536);
    pending = 0;
    repeat (8) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
